// File: rtl/led_pwm_pkg.sv
// Shared register map and CTRL bit positions for the LED PWM controller.
package led_pwm_pkg;
  localparam logic [3:0] ADDR_CTRL      = 4'h0;
  localparam logic [3:0] ADDR_BLINK_EN  = 4'h1;
  localparam logic [3:0] ADDR_PRESCALE  = 4'h2;
  localparam logic [3:0] ADDR_BLINK_PER = 4'h3;
  localparam logic [3:0] ADDR_STATUS    = 4'h4;
  localparam logic [3:0] ADDR_DUTY_BASE = 4'h8;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_INV = 1;
endpackage

// File: rtl/led_pwm_timebase.sv
// Prescaler, 8-bit PWM counter and blink phase generator; all state on falling clk.
module led_pwm_timebase (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] prescale,
  input  logic [7:0] blink_per,
  output logic [7:0] pwm_cnt,
  output logic       phase,
  output logic       wrap
);
  logic [7:0] pre_q, pre_d;
  logic [7:0] pwm_q, pwm_d;
  logic [7:0] blink_q, blink_d;
  logic       phase_q, phase_d;
  logic       tick;

  // >= rather than == so a lowered PRESCALE never strands the counter above it
  always_comb begin
    tick    = (pre_q >= prescale);
    pre_d   = tick ? 8'h00 : pre_q + 8'h01;
    pwm_d   = tick ? pwm_q + 8'h01 : pwm_q;
    wrap    = tick & (pwm_q == 8'hFF);
    blink_d = blink_q;
    phase_d = phase_q;
    if (wrap) begin
      if (blink_q >= blink_per) begin
        blink_d = 8'h00;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 8'h01;
      end
    end
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q   <= 8'h00;
      pwm_q   <= 8'h00;
      blink_q <= 8'h00;
      phase_q <= 1'b1;
    end else begin
      pre_q   <= pre_d;
      pwm_q   <= pwm_d;
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  assign pwm_cnt = pwm_q;
  assign phase   = phase_q;
endmodule

// File: rtl/led_pwm_ctrl.sv
// Bus-mapped multi-channel LED PWM controller with blink gating and selectable polarity.
module led_pwm_ctrl
  import led_pwm_pkg::*;
#(
  parameter int         NUM_CH       = 8,
  parameter logic [7:0] PRESCALE_RST = 8'h00,
  parameter logic [7:0] BLINK_RST    = 8'h00
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cs,
  input  logic              rwb,
  input  logic [3:0]        addr,
  input  logic [7:0]        i_data,
  output logic [7:0]        o_data,
  output logic [NUM_CH-1:0] o_leds
);
  logic [1:0]             ctrl_q, ctrl_d;
  logic [NUM_CH-1:0]      blink_en_q, blink_en_d;
  logic [7:0]             prescale_q, prescale_d;
  logic [7:0]             blink_per_q, blink_per_d;
  logic                   wrap_flag_q, wrap_flag_d;
  logic [NUM_CH-1:0][7:0] duty_q, duty_d;
  logic [7:0]             o_data_q, o_data_d;
  logic [NUM_CH-1:0]      leds_q, leds_d;
  logic [7:0]             rd_data;
  logic [7:0]             pwm_cnt;
  logic                   phase, wrap, rd, wr;

  assign rd = cs & rwb;
  assign wr = cs & ~rwb;

  led_pwm_timebase u_tb (
    .clk      (clk),
    .rst_n    (rst_n),
    .prescale (prescale_q),
    .blink_per(blink_per_q),
    .pwm_cnt  (pwm_cnt),
    .phase    (phase),
    .wrap     (wrap)
  );

  always_comb begin
    rd_data = 8'h00;
    case (addr)
      ADDR_CTRL:      rd_data = {6'b0, ctrl_q};
      ADDR_BLINK_EN:  rd_data[NUM_CH-1:0] = blink_en_q;
      ADDR_PRESCALE:  rd_data = prescale_q;
      ADDR_BLINK_PER: rd_data = blink_per_q;
      ADDR_STATUS:    rd_data = {6'b0, wrap_flag_q, phase};
      default: begin
        for (int i = 0; i < NUM_CH; i++)
          if (addr == ADDR_DUTY_BASE + 4'(i)) rd_data = duty_q[i];
      end
    endcase
  end

  always_comb begin
    ctrl_d      = ctrl_q;
    blink_en_d  = blink_en_q;
    prescale_d  = prescale_q;
    blink_per_d = blink_per_q;
    duty_d      = duty_q;
    o_data_d    = rd ? rd_data : o_data_q;
    // a wrap on the same edge as a STATUS read keeps the flag set
    wrap_flag_d = wrap | (wrap_flag_q & ~(rd & (addr == ADDR_STATUS)));
    if (wr) begin
      case (addr)
        ADDR_CTRL:      ctrl_d      = i_data[1:0];
        ADDR_BLINK_EN:  blink_en_d  = i_data[NUM_CH-1:0];
        ADDR_PRESCALE:  prescale_d  = i_data;
        ADDR_BLINK_PER: blink_per_d = i_data;
        default: begin
          for (int i = 0; i < NUM_CH; i++)
            if (addr == ADDR_DUTY_BASE + 4'(i)) duty_d[i] = i_data;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic raw, on;
    assign raw       = (pwm_cnt < duty_q[g]) | (duty_q[g] == 8'hFF);
    assign on        = ctrl_q[CTRL_EN] & raw & (~blink_en_q[g] | phase);
    assign leds_d[g] = ctrl_q[CTRL_INV] ? on : ~on;
  end

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_q      <= '0;
      blink_en_q  <= '0;
      prescale_q  <= PRESCALE_RST;
      blink_per_q <= BLINK_RST;
      wrap_flag_q <= 1'b0;
      duty_q      <= '0;
      o_data_q    <= 8'h00;
      leds_q      <= '1;
    end else begin
      ctrl_q      <= ctrl_d;
      blink_en_q  <= blink_en_d;
      prescale_q  <= prescale_d;
      blink_per_q <= blink_per_d;
      wrap_flag_q <= wrap_flag_d;
      duty_q      <= duty_d;
      o_data_q    <= o_data_d;
      leds_q      <= leds_d;
    end
  end

  assign o_data = o_data_q;
  assign o_leds = leds_q;
endmodule

// File: tb/tb_led_pwm_ctrl.sv
// Self-checking bench: cycle model of the LED controller plus directed literal checks.
module tb_led_pwm_ctrl;
  localparam int         NUM_CH = 8;
  localparam logic [7:0] P_RST  = 8'h03;
  localparam logic [7:0] B_RST  = 8'h02;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              cs = 1'b0;
  logic              rwb = 1'b1;
  logic [3:0]        addr = 4'h0;
  logic [7:0]        i_data = 8'h00;
  logic [7:0]        o_data;
  logic [NUM_CH-1:0] o_leds;

  int errors = 0;
  int checks = 0;

  led_pwm_ctrl #(.NUM_CH(NUM_CH), .PRESCALE_RST(P_RST), .BLINK_RST(B_RST)) dut (
    .clk(clk), .rst_n(rst_n), .cs(cs), .rwb(rwb), .addr(addr),
    .i_data(i_data), .o_data(o_data), .o_leds(o_leds)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [1:0]        m_ctrl;
  logic [NUM_CH-1:0] m_ben;
  int                m_prescale, m_bper, m_duty[NUM_CH];
  int                m_ticks, m_pre, m_wraps_since;
  logic              m_phase, m_flag;
  logic [NUM_CH-1:0] exp_leds;
  logic [7:0]        exp_data;

  task automatic m_reset();
    m_ctrl = 2'b00; m_ben = '0; m_prescale = P_RST; m_bper = B_RST;
    for (int i = 0; i < NUM_CH; i++) m_duty[i] = 0;
    m_ticks = 0; m_pre = 0; m_wraps_since = 0; m_phase = 1'b1; m_flag = 1'b0;
    exp_leds = '1; exp_data = 8'h00;
  endtask

  function automatic logic [7:0] m_read(input logic [3:0] a);
    int ai = int'(a);
    if (ai == 0) return {6'b0, m_ctrl};
    if (ai == 1) return 8'(m_ben);
    if (ai == 2) return 8'(m_prescale);
    if (ai == 3) return 8'(m_bper);
    if (ai == 4) return {6'b0, m_flag, m_phase};
    if (ai >= 8 && ai < 8 + NUM_CH) return 8'(m_duty[ai-8]);
    return 8'h00;
  endfunction

  task automatic m_step();
    logic [NUM_CH-1:0] nl;
    int  pwm;
    logic wrap, on;
    pwm = m_ticks % 256;
    for (int i = 0; i < NUM_CH; i++) begin
      on = m_ctrl[0] && (pwm < m_duty[i] || m_duty[i] == 255) && (!m_ben[i] || m_phase);
      nl[i] = m_ctrl[1] ? on : !on;
    end
    if (cs && rwb) exp_data = m_read(addr);
    wrap = 1'b0;
    if (m_pre >= m_prescale) begin
      m_pre = 0;
      m_ticks++;
      wrap = (m_ticks % 256 == 0);
    end else m_pre++;
    if (wrap) begin
      m_wraps_since++;
      if (m_wraps_since > m_bper) begin m_wraps_since = 0; m_phase = !m_phase; end
    end
    if (wrap) m_flag = 1'b1;
    else if (cs && rwb && addr == 4'h4) m_flag = 1'b0;
    if (cs && !rwb) begin
      case (int'(addr))
        0: m_ctrl = i_data[1:0];
        1: m_ben = i_data[NUM_CH-1:0];
        2: m_prescale = int'(i_data);
        3: m_bper = int'(i_data);
        default: if (int'(addr) >= 8 && int'(addr) < 8 + NUM_CH) m_duty[int'(addr)-8] = int'(i_data);
      endcase
    end
    exp_leds = nl;
  endtask

  initial begin
    m_reset();
    forever begin
      @(negedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else m_step();
    end
  end

  // compare on the rising edge, away from the falling active edge
  initial begin
    forever begin
      @(posedge clk);
      checks++;
      if (o_leds !== exp_leds) begin
        errors++;
        $display("FAIL model_leds t=%0t got=%b want=%b", $time, o_leds, exp_leds);
      end
      checks++;
      if (o_data !== exp_data) begin
        errors++;
        $display("FAIL model_data t=%0t got=%h want=%h", $time, o_data, exp_data);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk); #1;
    cs = 1'b1; rwb = 1'b0; addr = a; i_data = d;
    @(negedge clk); #1;
    cs = 1'b0; rwb = 1'b1;
  endtask

  task automatic bus_rd(input logic [3:0] a, output logic [7:0] d);
    @(negedge clk); #1;
    cs = 1'b1; rwb = 1'b1; addr = a;
    @(negedge clk); #1;
    cs = 1'b0;
    d = o_data;
  endtask

  task automatic count_low(input int bitn, input int n, output int lows);
    lows = 0;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      if (!o_leds[bitn]) lows++;
    end
  endtask

  // length of the current constant run of o_leds[0], sampled on rising edges
  task automatic run_len(output int len);
    logic v;
    v = o_leds[0];
    len = 1;
    while (len < 2000) begin
      @(posedge clk);
      if (o_leds[0] != v) break;
      len++;
    end
  endtask

  logic [7:0] rd;
  int n, r1, r2, hi1;

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_leds", int'(o_leds), 255);
    check("rst_odata", int'(o_data), 0);
    rst_n = 1'b1;
    bus_rd(4'h0, rd); check("rst_ctrl", int'(rd), 0);
    bus_rd(4'h1, rd); check("rst_blink_en", int'(rd), 0);
    bus_rd(4'h8, rd); check("rst_duty0", int'(rd), 0);
    bus_rd(4'h2, rd); check("rst_prescale", int'(rd), 3);
    bus_rd(4'h3, rd); check("rst_blink_per", int'(rd), 2);

    // duty sweep
    bus_wr(4'h2, 8'h00);
    bus_wr(4'h1, 8'h00);
    bus_wr(4'h0, 8'h01);
    bus_wr(4'h8, 8'h40);
    repeat (4) @(posedge clk);
    count_low(0, 256, n); check("duty40_lows", n, 64);
    bus_wr(4'h8, 8'h00);
    repeat (2) @(posedge clk);
    count_low(0, 256, n); check("duty00_lows", n, 0);
    bus_wr(4'h8, 8'hFF);
    repeat (2) @(posedge clk);
    count_low(0, 256, n); check("dutyFF_lows", n, 256);

    // blink
    bus_wr(4'h3, 8'h01);
    bus_wr(4'h1, 8'h01);
    bus_wr(4'h9, 8'hFF);
    hi1 = 0;
    run_len(r1);
    check("blink_first_edge_bounded", int'(r1 < 2000), 1);
    run_len(r1);
    for (int k = 0; k < 4; k++) if (o_leds[1]) hi1++;
    run_len(r2);
    check("blink_run1", r1, 512);
    check("blink_run2", r2, 512);
    count_low(1, 300, n); check("ch1_steady_low", n, 300);

    // polarity
    bus_wr(4'hA, 8'hFF);
    bus_wr(4'h1, 8'h00);
    bus_wr(4'h0, 8'h03);
    repeat (2) @(posedge clk); #1;
    check("inv_ch2_on", int'(o_leds[2]), 1);
    check("inv_ch0_on", int'(o_leds[0]), 1);
    bus_wr(4'h0, 8'h02);
    repeat (2) @(posedge clk); #1;
    check("inv_disabled", int'(o_leds), 0);

    // bus edge cases
    bus_wr(4'h7, 8'h5A);
    bus_rd(4'h7, rd); check("unmapped_rd", int'(rd), 0);
    bus_rd(4'h4, rd);
    repeat (300) @(posedge clk);
    bus_rd(4'h4, rd); check("status_wrap_set", int'(rd[1]), 1);
    bus_rd(4'h4, rd); check("status_wrap_clr", int'(rd[1]), 0);

    // async reset mid-blink
    bus_wr(4'h0, 8'h01);
    bus_wr(4'h1, 8'h01);
    repeat (700) @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    #1 check("async_rst_leds", int'(o_leds), 255);
    @(posedge clk); #1 rst_n = 1'b1;
    bus_rd(4'h0, rd); check("post_rst_ctrl", int'(rd), 0);
    bus_rd(4'h1, rd); check("post_rst_blink_en", int'(rd), 0);
    bus_rd(4'h2, rd); check("post_rst_prescale", int'(rd), 3);
    bus_rd(4'h3, rd); check("post_rst_blink_per", int'(rd), 2);
    bus_rd(4'h8, rd); check("post_rst_duty0", int'(rd), 0);
    bus_rd(4'h4, rd); check("post_rst_status", int'(rd), 1);
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/led_pwm_ctrl.md
Name: led_pwm_ctrl

Overview:
- Bus-mapped LED controller for the 6502 system; parametrised successor to the single-register LED latch.
- Drives NUM_CH LED outputs, each with an 8-bit PWM brightness and an optional blink gate.
- Holds a small register file on the 8-bit CPU data bus, with cs, rwb and addr decoded upstream.
- Outputs are active-low by default to suit on-board LEDs; polarity is selectable.

Parameters:
- NUM_CH, 8, number of LED channels (1..8).
- PRESCALE_RST, 8'h00, reset value of the PRESCALE register.
- BLINK_RST, 8'h00, reset value of the BLINK_PER register.

Ports:
- clk  in  1  system clock; all state updates on the falling edge.
- rst_n  in  1  asynchronous active-low reset.
- cs  in  1  chip select.
- rwb  in  1  1 = read, 0 = write.
- addr  in  4  register address.
- i_data  in  8  write data.
- o_data  out  8  registered read data.
- o_leds  out  NUM_CH  LED drive; active-low unless CTRL.INV = 1.

Behaviour:
- Decided: one clock clk; reset rst_n is asynchronous and active-low.
- All flops update on negedge clk or negedge rst_n.
- Register map:
  - 0x0 CTRL: bit0 EN, bit1 INV; other bits read 0.
  - 0x1 BLINK_EN: bit i enables blink for channel i; bits >= NUM_CH read 0.
  - 0x2 PRESCALE.
  - 0x3 BLINK_PER.
  - 0x4 STATUS (read-only): bit0 blink phase, bit1 sticky PWM-wrap flag, cleared by reading STATUS.
  - 0x8 .. 0x8+NUM_CH-1: DUTY[i].
  - Unmapped: reads return 0x00; writes are ignored.
- Bus access:
  - Write: cs & ~rwb updates the addressed register at that edge.
  - Read: cs & rwb loads o_data at that edge; o_data holds its value otherwise.
- Reset values:
  - All registers 0, except PRESCALE = PRESCALE_RST and BLINK_PER = BLINK_RST.
  - o_data = 0x00.
  - All counters 0; blink phase = 1.
  - o_leds = all ones (LEDs off).
- Prescaler:
  - pre_cnt increments each edge.
  - tick = (pre_cnt >= PRESCALE); on tick pre_cnt returns to 0.
  - Tick period = PRESCALE+1 clocks. The >= compare means lowering PRESCALE mid-count never stalls.
- PWM counter:
  - pwm_cnt (8 bits) increments on tick; wraps 0xFF -> 0x00.
  - The wrap sets the STATUS.bit1 flag and advances blink logic.
- Blink:
  - blink_cnt increments on each PWM wrap.
  - When blink_cnt >= BLINK_PER at a wrap, phase toggles and blink_cnt returns to 0.
  - Half-period = (BLINK_PER+1) PWM periods.
- Channel on-state:
  - raw_i = (pwm_cnt < DUTY[i]) | (DUTY[i] == 0xFF).
  - DUTY 0 is always off; 0xFF is always on.
  - on_i = EN & raw_i & (~BLINK_EN[i] | phase).
- Output:
  - o_leds[i] = INV ? on_i : ~on_i.
  - Registered: exactly one edge of latency after counters and registers change.
- Simultaneous events:
  - A STATUS read on the same edge the wrap flag sets: o_data shows the old flag, and the flag stays set (set wins over clear).
  - A DUTY write takes effect on the next compare; no wait for a period boundary.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous), and o_leds goes all-ones without waiting for a clock.

Decomposition:
- Package led_pwm_pkg holds the address constants (ADDR_CTRL, ADDR_BLINK_EN, ADDR_PRESCALE, ADDR_BLINK_PER, ADDR_STATUS, ADDR_DUTY_BASE) and the CTRL bit indices.
- One sub-module, led_pwm_timebase: prescaler, pwm_cnt, blink_cnt, phase, wrap pulse.
- The top level holds the register file, the per-channel compare and the output registers.

Test Plan:
- Reset check: hold rst_n=0 -> o_leds = all ones and o_data = 0x00; after release, reads of 0x0/0x1/0x8 return 0x00 and 0x2 returns PRESCALE_RST.
- Duty sweep:
  - Setup: PRESCALE=0, CTRL=0x01, DUTY[0]=0x40.
  - Expected: o_leds[0] low for exactly 64 of every 256 clocks.
  - Then DUTY[0]=0x00 -> always high; DUTY[0]=0xFF -> always low.
- Blink:
  - Setup: PRESCALE=0, BLINK_PER=1, BLINK_EN=0x01, DUTY[0]=0xFF, EN=1.
  - Expected: o_leds[0] alternates 512 clocks low / 512 clocks high.
  - Channel 1 with DUTY=0xFF and no blink stays low throughout.
- Polarity: CTRL=0x03 with DUTY[2]=0xFF -> o_leds[2]=1. Then CTRL=0x02 -> all outputs 0.
- Bus edge cases:
  - Write 0x5A to 0x7 and read it back -> 0x00.
  - Read STATUS after one full PWM period -> bit1 = 1; immediate reread -> bit1 = 0.
- Async reset mid-blink: pulse rst_n low between clock edges -> o_leds all ones before the next clk edge; all registers read reset values.
